// File: rtl/pulse_arb_pkg.sv
// Shared types, default sizes and the round-robin pick helper for pulse_event_arbiter.
package pulse_arb_pkg;

    localparam int DEF_N_CH  = 4;
    localparam int DEF_CNT_W = 8;
    localparam int MAX_CH    = 16;

    typedef enum logic {
        SLOT_EMPTY,
        SLOT_OFFER
    } slot_state_t;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } rr_pick_t;

    // First set bit at or after ptr, wrapping within the n_ch live channels.
    function automatic rr_pick_t rr_pick(input logic [MAX_CH-1:0] pend,
                                         input int ptr,
                                         input int n_ch);
        rr_pick_t   r;
        int         idx;
        logic [3:0] sel;
        r = '0;
        for (int k = 0; k < MAX_CH; k++) begin
            idx = ptr + k;
            if (idx >= n_ch) idx = idx - n_ch;
            sel = 4'(idx);
            if (k < n_ch && !r.found && pend[sel]) begin
                r.found = 1'b1;
                r.idx   = sel;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rising_edge_capture.sv
// One channel of level-to-pulse: remembers the previous level and flags a 0->1 step.
module rising_edge_capture (
    input  logic clk,
    input  logic reset,
    input  logic x_i,
    output logic rise_o
);

    logic prev_q;

    // NOTE: clocked state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) prev_q <= 1'b0;
        else       prev_q <= x_i;
    end

    assign rise_o = x_i & ~prev_q;

endmodule

// File: rtl/pulse_event_arbiter.sv
// Latches rising edges per channel and serialises them round-robin onto a valid/ready port.
// Define PULSE_ARB_DROP_CNT_EN to add the saturating drop_cnt output.
module pulse_event_arbiter
    import pulse_arb_pkg::*;
#(
    parameter int N_CH = DEF_N_CH
`ifdef PULSE_ARB_DROP_CNT_EN
    , parameter int CNT_W = DEF_CNT_W
`endif
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_CH-1:0]         X,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [$clog2(N_CH)-1:0] out_id,
    output logic [N_CH-1:0]         pending,
    output logic                    overflow
`ifdef PULSE_ARB_DROP_CNT_EN
    , output logic [CNT_W-1:0]      drop_cnt
`endif
);

    localparam int ID_W = $clog2(N_CH);

    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] pending_q, pending_d;
    logic [N_CH-1:0] grant_oh;
    logic [N_CH-1:0] dropped;
    logic [ID_W-1:0] id_q, id_d;
    logic [ID_W-1:0] rr_q, rr_d;
    logic            overflow_q, overflow_d;
    logic            load;
    slot_state_t     state_q, state_d;
    rr_pick_t        pick;

    for (genvar i = 0; i < N_CH; i++) begin : g_cap
        rising_edge_capture u_cap (
            .clk    (clk),
            .reset  (reset),
            .x_i    (X[i]),
            .rise_o (rise[i])
        );
    end

    // NOTE: every signal gets a default first so no path through the block infers a latch.
    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        rr_d     = rr_q;
        grant_oh = '0;
        load     = (state_q == SLOT_EMPTY) || out_ready;
        pick     = rr_pick(MAX_CH'(pending_q), int'(rr_q), N_CH);
        if (load) begin
            if (pick.found) begin
                state_d  = SLOT_OFFER;
                id_d     = ID_W'(pick.idx);
                grant_oh = N_CH'(1) << pick.idx;
                rr_d     = (int'(pick.idx) == N_CH - 1) ? '0 : ID_W'(pick.idx) + 1'b1;
            end else begin
                state_d = SLOT_EMPTY;
            end
        end
    end

    // An edge on a bit that stays pending past this cycle has nowhere to go.
    assign dropped    = rise & pending_q & ~grant_oh;
    assign pending_d  = (pending_q & ~grant_oh) | rise;
    assign overflow_d = overflow_q | (|dropped);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= SLOT_EMPTY;
            id_q       <= '0;
            rr_q       <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            rr_q       <= rr_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    assign out_valid = (state_q == SLOT_OFFER);
    assign out_id    = id_q;
    assign pending   = pending_q;
    assign overflow  = overflow_q;

`ifdef PULSE_ARB_DROP_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W+4:0] cnt_sum;

    always_comb begin
        cnt_sum = {5'b0, cnt_q};
        for (int i = 0; i < N_CH; i++) cnt_sum = cnt_sum + (CNT_W+5)'(dropped[i]);
        cnt_d = (cnt_sum > {5'b0, CNT_MAX}) ? CNT_MAX : cnt_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign drop_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_pulse_event_arbiter.sv
// Self-checking bench for pulse_event_arbiter (N_CH=4): vector table, corner sequences, event scoreboard.
module tb_pulse_event_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] X;
    logic       out_ready;
    logic       out_valid;
    logic [1:0] out_id;
    logic [3:0] pending;
    logic       overflow;
`ifdef PULSE_ARB_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int exp_id;
    int n_valid;

    typedef struct {
        logic [3:0] x;
        logic       rdy;
        logic       e_valid;
        logic [1:0] e_id;
        logic [3:0] e_pend;
        logic       e_ovf;
        int         e_drop;
        int         push_id;
    } vec_t;

    vec_t vecs[20];

    pulse_event_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .X         (X),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_id    (out_id),
        .pending   (pending),
        .overflow  (overflow)
`ifdef PULSE_ARB_DROP_CNT_EN
        , .drop_cnt (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        X = 4'b0000;
        out_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    // Handshakes are judged mid-cycle, where valid/ready are stable for the coming edge.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_pop: handshake on id %0d with no event expected", out_id);
            end else begin
                exp_id = exp_q.pop_front();
                check("sb_id", 32'(out_id), 32'(exp_id));
            end
        end
    end

    initial begin
        //          x        rdy   val   id     pend     ovf  drop push
        vecs = '{
            '{4'b1011, 1'b1, 1'b0, 2'd0, 4'b1011, 1'b0, 0, -1},
            '{4'b1011, 1'b1, 1'b1, 2'd0, 4'b1010, 1'b0, 0,  0},
            '{4'b1011, 1'b1, 1'b1, 2'd1, 4'b1000, 1'b0, 0,  1},
            '{4'b1011, 1'b1, 1'b1, 2'd3, 4'b0000, 1'b0, 0,  3},
            '{4'b1011, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 0, -1},
            '{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 0, -1},
            '{4'b1001, 1'b1, 1'b0, 2'd0, 4'b1001, 1'b0, 0, -1},
            '{4'b1001, 1'b1, 1'b1, 2'd0, 4'b1000, 1'b0, 0,  0},
            '{4'b1001, 1'b1, 1'b1, 2'd3, 4'b0000, 1'b0, 0,  3},
            '{4'b1001, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 0, -1},
            '{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 0, -1},
            '{4'b0001, 1'b1, 1'b0, 2'd0, 4'b0001, 1'b0, 0, -1},
            '{4'b0000, 1'b0, 1'b1, 2'd0, 4'b0000, 1'b0, 0,  0},
            '{4'b0001, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b0, 0, -1},
            '{4'b0000, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b0, 0, -1},
            '{4'b0001, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b0, 0,  0},
            '{4'b0000, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b0, 0, -1},
            '{4'b0001, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b1, 1, -1},
            '{4'b0000, 1'b1, 1'b1, 2'd0, 4'b0000, 1'b1, 1,  0},
            '{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b1, 1, -1}
        };

        // Reset with all levels already high, then release.
        reset = 1'b1;
        X = 4'b1111;
        out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step();
            check("rst_valid", 32'(out_valid), 0);
            check("rst_id", 32'(out_id), 0);
            check("rst_pend", 32'(pending), 0);
            check("rst_ovf", 32'(overflow), 0);
`ifdef PULSE_ARB_DROP_CNT_EN
            check("rst_drop", 32'(drop_cnt), 0);
`endif
        end
        reset = 1'b0;
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(2);
        exp_q.push_back(3);
        step();
        check("rel_pend", 32'(pending), 32'h0f);
        check("rel_valid", 32'(out_valid), 0);
        for (int c = 0; c < 4; c++) begin
            step();
            check("rel_seq_valid", 32'(out_valid), 1);
            check("rel_seq_id", 32'(out_id), 32'(c));
        end
        step();
        check("rel_done_valid", 32'(out_valid), 0);
        check("rel_done_pend", 32'(pending), 0);

        // Vector table: round-robin order, pointer wrap, edge-during-grant, overflow.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            X = vecs[i].x;
            out_ready = vecs[i].rdy;
            if (vecs[i].push_id >= 0) exp_q.push_back(vecs[i].push_id);
            step();
            check($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
            if (vecs[i].e_valid) check($sformatf("v%0d_id", i), 32'(out_id), 32'(vecs[i].e_id));
            check($sformatf("v%0d_pend", i), 32'(pending), 32'(vecs[i].e_pend));
            check($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vecs[i].e_ovf));
`ifdef PULSE_ARB_DROP_CNT_EN
            check($sformatf("v%0d_drop", i), 32'(drop_cnt), 32'(vecs[i].e_drop));
`endif
        end

        // Backpressure: one event on ch2 held for five cycles.
        do_reset();
        X = 4'b0100;
        exp_q.push_back(2);
        step();
        check("bp_pend", 32'(pending), 32'h4);
        X = 4'b0000;
        for (int c = 0; c < 5; c++) begin
            step();
            check("bp_valid", 32'(out_valid), 1);
            check("bp_id", 32'(out_id), 2);
        end
        out_ready = 1'b1;
        step();
        check("bp_after_valid", 32'(out_valid), 0);

        // Overflow: ch1 re-pulsed twice while its first event is stuck in the slot.
        do_reset();
        X = 4'b0010;
        exp_q.push_back(1);
        step();
        X = 4'b0000;
        step();
        check("ov_offer_id", 32'(out_id), 1);
        check("ov_offer_pend", 32'(pending), 0);
        X = 4'b0010;
        step();
        check("ov_first_pend", 32'(pending), 32'h2);
        check("ov_first_ovf", 32'(overflow), 0);
        X = 4'b0000;
        step();
        X = 4'b0010;
        step();
        check("ov_second_ovf", 32'(overflow), 1);
        check("ov_second_pend", 32'(pending), 32'h2);
`ifdef PULSE_ARB_DROP_CNT_EN
        check("ov_drop_cnt", 32'(drop_cnt), 1);
`endif
        X = 4'b0000;
        out_ready = 1'b1;
        exp_q.push_back(1);
        step();
        check("ov_regrant_valid", 32'(out_valid), 1);
        check("ov_regrant_id", 32'(out_id), 1);
        step();
        check("ov_end_valid", 32'(out_valid), 0);
        check("ov_sticky", 32'(overflow), 1);

        // Long level on ch3 yields exactly one event.
        do_reset();
        out_ready = 1'b1;
        X = 4'b1000;
        exp_q.push_back(3);
        n_valid = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (out_valid) begin
                n_valid++;
                check("long_id", 32'(out_id), 3);
            end
        end
        check("long_events", 32'(n_valid), 1);
        X = 4'b0000;

        // Asynchronous reset while an event is offered and two more are pending.
        do_reset();
        X = 4'b0001;
        step();
        X = 4'b0111;
        step();
        check("mid_valid", 32'(out_valid), 1);
        check("mid_pend", 32'(pending), 32'h6);
        #3;
        reset = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 0);
        check("mid_rst_pend", 32'(pending), 0);
        check("mid_rst_ovf", 32'(overflow), 0);
        X = 4'b0000;
        step();
        reset = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            check("post_rst_valid", 32'(out_valid), 0);
            check("post_rst_pend", 32'(pending), 0);
        end

        check("sb_drained", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
